// File: rtl/pipe_fetch_queue.sv
// rtl/pipe_fetch_queue.sv - decoupled instruction fetch unit with in-order DEPTH-entry queue
// Slots are allocated at grant and filled in grant order; a redirect flushes the queue
// and converts every in-flight fetch into a pending discard.
module pipe_fetch_queue #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              PC_STEP  = 2,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [PC_W-1:0]    out_pc_o,
  output logic [PC_W-1:0]    out_next_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    fetch_pc;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      fill_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      discard_cnt;
  logic [CW-1:0]      outstanding_next;

  logic [PC_W-1:0]    slot_pc    [DEPTH];
  logic [INSTR_W-1:0] slot_instr [DEPTH];
  logic [DEPTH-1:0]   slot_filled;

  logic grant;
  logic resp;
  logic keep;
  logic drop;
  logic pop;

  assign imem_req_o  = !rst_i && !redirect_i && (discard_cnt == '0) && (count < CW'(DEPTH));
  assign imem_addr_o = fetch_pc;

  assign grant = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp  = imem_rvalid_i && (outstanding != '0);
  assign drop  = resp && (discard_cnt != '0);
  assign keep  = resp && (discard_cnt == '0);

  assign out_valid_o   = slot_filled[rd_ptr] && !redirect_i && !rst_i;
  assign pop           = out_valid_o && out_ready_i;
  assign out_instr_o   = slot_instr[rd_ptr];
  assign out_pc_o      = slot_pc[rd_ptr];
  assign out_next_pc_o = slot_pc[rd_ptr] + PC_W'(PC_STEP);

  assign outstanding_next = outstanding + CW'(grant) - CW'(resp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      slot_filled <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_i) begin
        fetch_pc    <= redirect_pc_i;
        wr_ptr      <= '0;
        fill_ptr    <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        slot_filled <= '0;
        // Every fetch still in flight after this cycle is stale, including earlier discards.
        discard_cnt <= outstanding_next;
      end else begin
        if (grant) begin
          fetch_pc            <= fetch_pc + PC_W'(PC_STEP);
          slot_filled[wr_ptr] <= 1'b0;
          wr_ptr              <= wr_ptr + AW'(1);
        end
        if (keep) begin
          slot_filled[fill_ptr] <= 1'b1;
          fill_ptr              <= fill_ptr + AW'(1);
        end
        if (drop) begin
          discard_cnt <= discard_cnt - CW'(1);
        end
        if (pop) begin
          slot_filled[rd_ptr] <= 1'b0;
          rd_ptr              <= rd_ptr + AW'(1);
        end
        count <= count + CW'(grant) - CW'(pop);
      end
    end
  end

  // Slot payload needs no reset; the filled flags qualify it.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      slot_pc[wr_ptr] <= fetch_pc;
    end
    if (keep && !redirect_i) begin
      slot_instr[fill_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// tb/tb_pipe_fetch_queue.sv - directed bench for pipe_fetch_queue
module tb_pipe_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [15:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [15:0] rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] npc;

  logic        rst8;
  logic        req8;
  logic [7:0]  addr8;
  logic        gnt8;
  logic        rvalid8;
  logic [15:0] rdata8;
  logic        redirect8;
  logic [7:0]  redirect_pc8;
  logic        valid8;
  logic        ready8;
  logic [15:0] instr8;
  logic [7:0]  pc8;
  logic [7:0]  npc8;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int p        = 0;

  logic [15:0] mq_addr [$];
  int          mq_due  [$];
  logic        pend8;
  logic [7:0]  pend_a8;

  always #5 clk = ~clk;

  pipe_fetch_queue dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .out_valid_o(valid), .out_ready_i(ready), .out_instr_o(instr),
    .out_pc_o(pc), .out_next_pc_o(npc)
  );

  pipe_fetch_queue #(.PC_W(8), .RESET_PC(8'hFC)) dut8 (
    .clk_i(clk), .rst_i(rst8),
    .imem_req_o(req8), .imem_addr_o(addr8), .imem_gnt_i(gnt8),
    .imem_rvalid_i(rvalid8), .imem_rdata_i(rdata8),
    .redirect_i(redirect8), .redirect_pc_i(redirect_pc8),
    .out_valid_o(valid8), .out_ready_i(ready8), .out_instr_o(instr8),
    .out_pc_o(pc8), .out_next_pc_o(npc8)
  );

  // Memory for the 16-bit core: fixed latency lat, rdata = addr, cleared by reset.
  initial begin
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(posedge clk);
      p++;
      #1;
      if (mq_due.size() > 0 && mq_due[0] == p) begin
        rvalid = 1'b1;
        rdata  = mq_addr[0];
        mq_addr.delete(0);
        mq_due.delete(0);
      end else begin
        rvalid = 1'b0;
      end
      #5;
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (req && gnt) begin
        mq_addr.push_back(addr);
        mq_due.push_back(p + lat);
      end
    end
  end

  // Memory for the 8-bit core: 1-cycle latency, rdata = addr.
  initial begin
    rvalid8 = 1'b0;
    rdata8  = '0;
    pend8   = 1'b0;
    pend_a8 = '0;
    forever begin
      @(posedge clk);
      #1;
      rvalid8 = pend8;
      rdata8  = {8'h00, pend_a8};
      #5;
      pend8   = req8 && gnt8 && !rst8;
      pend_a8 = addr8;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int  grants;
    logic seen;
    rst = 1'b1; rst8 = 1'b1;
    gnt = 1'b1; gnt8 = 1'b1;
    ready = 1'b1; ready8 = 1'b1;
    redirect = 1'b0; redirect_pc = '0;
    redirect8 = 1'b0; redirect_pc8 = '0;

    // Reset state
    tick();
    #2;
    check("rst valid", 32'(valid), 0);
    check("rst req", 32'(req), 0);

    // 1-cycle memory, streaming
    lat = 1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #2;
      check($sformatf("t1 valid c%0d", c), 32'(valid), 32'(c >= 2));
      if (c == 0) check("t1 addr c0", 32'(addr), 0);
      if (c == 1) check("t1 addr c1", 32'(addr), 2);
      if (c >= 2) begin
        check($sformatf("t1 pc c%0d", c), 32'(pc), 32'(2 * (c - 2)));
        check($sformatf("t1 npc c%0d", c), 32'(npc), 32'(2 * (c - 2) + 2));
        check($sformatf("t1 instr c%0d", c), 32'(instr), 32'(2 * (c - 2)));
      end
    end

    // Backpressure until full
    ready = 1'b0;
    do_reset();
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #2;
      if (req && gnt) grants++;
    end
    check("t2 grants", 32'(grants), 4);
    check("t2 req full", 32'(req), 0);
    check("t2 valid held", 32'(valid), 1);
    check("t2 pc held", 32'(pc), 0);
    for (int c = 10; c < 15; c++) begin
      tick();
      ready = 1'b1;
      #2;
      check($sformatf("t2 pc c%0d", c), 32'(pc), 32'(2 * (c - 10)));
      if (c == 10) check("t2 req c10", 32'(req), 0);
      if (c == 11) begin
        check("t2 req c11", 32'(req), 1);
        check("t2 addr c11", 32'(addr), 8);
      end
    end

    // 3-cycle memory, redirect with 3 in flight
    lat = 3;
    do_reset();
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      redirect    = (c == 3);
      redirect_pc = 16'h0040;
      #2;
      if (c < 10) seen = seen | valid;
      if (c == 3) check("t3 req redirect", 32'(req), 0);
      if (c == 4 || c == 5) check($sformatf("t3 req c%0d", c), 32'(req), 0);
      if (c == 6) begin
        check("t3 req c6", 32'(req), 1);
        check("t3 addr c6", 32'(addr), 32'h40);
      end
      if (c >= 10) begin
        check($sformatf("t3 valid c%0d", c), 32'(valid), 1);
        check($sformatf("t3 pc c%0d", c), 32'(pc), 32'(16'h0040 + 2 * (c - 10)));
        check($sformatf("t3 instr c%0d", c), 32'(instr), 32'(16'h0040 + 2 * (c - 10)));
      end
    end
    check("t3 no stale valid", 32'(seen), 0);

    // 2-cycle memory, redirect coinciding with a response
    lat = 2;
    do_reset();
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      redirect    = (c == 2);
      redirect_pc = 16'h0100;
      #2;
      if (c >= 2 && c < 7) seen = seen | valid;
      if (c == 3) check("t4 req c3", 32'(req), 0);
      if (c == 4) begin
        check("t4 req c4", 32'(req), 1);
        check("t4 addr c4", 32'(addr), 32'h100);
      end
      if (c == 7) begin
        check("t4 valid c7", 32'(valid), 1);
        check("t4 pc c7", 32'(pc), 32'h100);
      end
    end
    redirect = 1'b0;
    check("t4 no stale valid", 32'(seen), 0);

    // Mid-stream reset with 2 outstanding
    lat = 3;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      rst = (c == 2);
      #2;
      if (c == 2) begin
        check("t6 req in rst", 32'(req), 0);
        check("t6 valid in rst", 32'(valid), 0);
      end
      if (c == 3) begin
        check("t6 valid after rst", 32'(valid), 0);
        check("t6 addr after rst", 32'(addr), 0);
        check("t6 req after rst", 32'(req), 1);
      end
      if (c >= 3 && c < 7) check($sformatf("t6 idle c%0d", c), 32'(valid), 0);
      if (c >= 7) begin
        check($sformatf("t6 valid c%0d", c), 32'(valid), 1);
        check($sformatf("t6 pc c%0d", c), 32'(pc), 32'(2 * (c - 7)));
      end
    end

    // 8-bit PC wrap
    rst8 = 1'b1;
    tick();
    tick();
    rst8 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      #2;
      check($sformatf("t5 valid c%0d", c), 32'(valid8), 32'(c >= 2));
      if (c >= 2) begin
        check($sformatf("t5 pc c%0d", c), 32'(pc8), 32'(8'(8'hFC + 2 * (c - 2))));
        check($sformatf("t5 npc c%0d", c), 32'(npc8), 32'(8'(8'hFE + 2 * (c - 2))));
        check($sformatf("t5 instr c%0d", c), 32'(instr8), 32'(8'(8'hFC + 2 * (c - 2))));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
